// File: rtl/jtframe_romrq_arb.sv
// Round-robin arbiter that shares one SDRAM read port among N cached ROM requesters.
// One transaction is in flight at a time; a watchdog aborts reads the SDRAM never completes.
module jtframe_romrq_arb #(
  parameter int unsigned N   = 4,
  parameter int unsigned TOW = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [N-1:0]      slot_req,
  input  logic [22*N-1:0]   slot_addr,
  output logic [N-1:0]      slot_we,
  output logic              din_ok,
  output logic [31:0]       dout,
  output logic              sdram_req,
  output logic [21:0]       sdram_addr,
  input  logic              sdram_ack,
  input  logic              data_rdy,
  input  logic [31:0]       data_read,
  output logic              busy,
  output logic              timeout
);

  localparam int unsigned IdxW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {StIdle, StReq, StData, StDone} state_e;

  state_e            state_q, state_d;
  logic [IdxW-1:0]   last_q, last_d;
  logic [IdxW-1:0]   winner_q, winner_d;
  logic [N-1:0]      slot_we_q, slot_we_d;
  logic              din_ok_q, din_ok_d;
  logic [31:0]       dout_q, dout_d;
  logic              sdram_req_q, sdram_req_d;
  logic [21:0]       sdram_addr_q, sdram_addr_d;
  logic              timeout_q, timeout_d;
  logic [TOW-1:0]    wdog_q, wdog_d;

  logic              pick_found;
  logic [IdxW-1:0]   pick_idx;
  logic [IdxW-1:0]   cand_idx;
  logic [21:0]       pick_addr;
  logic [TOW-1:0]    wdog_inc;
  logic              wdog_expire;

  // Search starts one past the last served slot, so the last winner has lowest priority.
  always_comb begin
    pick_found = 1'b0;
    pick_idx   = '0;
    cand_idx   = '0;
    for (int unsigned i = 1; i <= N; i++) begin
      cand_idx = IdxW'((32'(last_q) + i) % N);
      if (!pick_found && slot_req[cand_idx]) begin
        pick_found = 1'b1;
        pick_idx   = cand_idx;
      end
    end
  end

  always_comb begin
    pick_addr = '0;
    for (int unsigned k = 0; k < N; k++) begin
      if (pick_idx == IdxW'(k)) begin
        pick_addr = slot_addr[22*k +: 22];
      end
    end
  end

  assign wdog_inc    = wdog_q + 1'b1;
  assign wdog_expire = (wdog_inc == {TOW{1'b1}});

  always_comb begin
    state_d      = state_q;
    last_d       = last_q;
    winner_d     = winner_q;
    slot_we_d    = slot_we_q;
    din_ok_d     = 1'b0;
    dout_d       = dout_q;
    sdram_req_d  = sdram_req_q;
    sdram_addr_d = sdram_addr_q;
    timeout_d    = 1'b0;
    wdog_d       = wdog_q;

    case (state_q)
      StIdle: begin
        if (pick_found) begin
          slot_we_d    = N'(1) << pick_idx;
          sdram_addr_d = pick_addr;
          sdram_req_d  = 1'b1;
          winner_d     = pick_idx;
          wdog_d       = '0;
          state_d      = StReq;
        end
      end
      StReq: begin
        // Ack and data in the same cycle go straight to data delivery.
        if (sdram_ack && data_rdy) begin
          sdram_req_d = 1'b0;
          dout_d      = data_read;
          din_ok_d    = 1'b1;
          state_d     = StDone;
        end else if (wdog_expire) begin
          sdram_req_d = 1'b0;
          slot_we_d   = '0;
          timeout_d   = 1'b1;
          last_d      = winner_q;
          state_d     = StIdle;
        end else begin
          wdog_d = wdog_inc;
          if (sdram_ack) begin
            sdram_req_d = 1'b0;
            state_d     = StData;
          end
        end
      end
      StData: begin
        if (data_rdy) begin
          dout_d   = data_read;
          din_ok_d = 1'b1;
          state_d  = StDone;
        end else if (wdog_expire) begin
          slot_we_d = '0;
          timeout_d = 1'b1;
          last_d    = winner_q;
          state_d   = StIdle;
        end else begin
          wdog_d = wdog_inc;
        end
      end
      StDone: begin
        slot_we_d = '0;
        last_d    = winner_q;
        state_d   = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= StIdle;
      last_q       <= IdxW'(N - 1);
      winner_q     <= '0;
      slot_we_q    <= '0;
      din_ok_q     <= 1'b0;
      dout_q       <= '0;
      sdram_req_q  <= 1'b0;
      sdram_addr_q <= '0;
      timeout_q    <= 1'b0;
      wdog_q       <= '0;
    end else begin
      state_q      <= state_d;
      last_q       <= last_d;
      winner_q     <= winner_d;
      slot_we_q    <= slot_we_d;
      din_ok_q     <= din_ok_d;
      dout_q       <= dout_d;
      sdram_req_q  <= sdram_req_d;
      sdram_addr_q <= sdram_addr_d;
      timeout_q    <= timeout_d;
      wdog_q       <= wdog_d;
    end
  end

  assign slot_we    = slot_we_q;
  assign din_ok     = din_ok_q;
  assign dout       = dout_q;
  assign sdram_req  = sdram_req_q;
  assign sdram_addr = sdram_addr_q;
  assign timeout    = timeout_q;
  assign busy       = (state_q != StIdle);

endmodule

// File: tb/tb_jtframe_romrq_arb.sv
// Bench for jtframe_romrq_arb: directed scenarios plus randomized grants checked
// against a round-robin reference computed from a rotated request mask.
module tb_jtframe_romrq_arb;

  localparam int N   = 4;
  localparam int TOW = 4;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic [N-1:0]    slot_req = '0;
  logic [22*N-1:0] slot_addr = '0;
  logic [N-1:0]    slot_we;
  logic            din_ok;
  logic [31:0]     dout;
  logic            sdram_req;
  logic [21:0]     sdram_addr;
  logic            sdram_ack = 1'b0;
  logic            data_rdy = 1'b0;
  logic [31:0]     data_read = '0;
  logic            busy;
  logic            timeout;

  int n_cmp = 0;
  int n_fail = 0;
  int model_last;
  logic [21:0] addr_tbl [N];

  jtframe_romrq_arb #(.N(N), .TOW(TOW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .slot_req  (slot_req),
    .slot_addr (slot_addr),
    .slot_we   (slot_we),
    .din_ok    (din_ok),
    .dout      (dout),
    .sdram_req (sdram_req),
    .sdram_addr(sdram_addr),
    .sdram_ack (sdram_ack),
    .data_rdy  (data_rdy),
    .data_read (data_read),
    .busy      (busy),
    .timeout   (timeout)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL global_time_limit: simulation did not finish");
    $fatal(1);
  end

  // Reference: rotate the mask so the slot after the last winner is bit 0, take the lowest set bit.
  function automatic int exp_winner(input logic [N-1:0] mask, input int last);
    logic [2*N-1:0] dbl;
    logic [N-1:0]   rot;
    int start, w;
    start = (last + 1) % N;
    dbl = {mask, mask} >> start;
    rot = dbl[N-1:0];
    w = -1;
    for (int i = N - 1; i >= 0; i--) if (rot[i]) w = (start + i) % N;
    return w;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load_addrs();
    for (int k = 0; k < N; k++) begin
      addr_tbl[k] = 22'($urandom);
      slot_addr[22*k +: 22] = addr_tbl[k];
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    slot_req = '0;
    sdram_ack = 1'b0;
    data_rdy = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    model_last = N - 1;
  endtask

  // Called right after the grant edge. ack_dly>=1 edges after grant; data_dly edges after ack.
  task automatic serve(input int ack_dly, input int data_dly, input logic [31:0] d,
                       input bit stray);
    repeat (ack_dly - 1) begin
      data_rdy = stray;
      data_read = $urandom;
      tick();
      data_rdy = 1'b0;
    end
    sdram_ack = 1'b1;
    if (data_dly == 0) begin
      data_rdy = 1'b1;
      data_read = d;
    end
    tick();
    sdram_ack = 1'b0;
    data_rdy = 1'b0;
    if (data_dly > 0) begin
      repeat (data_dly - 1) tick();
      data_rdy = 1'b1;
      data_read = d;
      tick();
      data_rdy = 1'b0;
    end
    data_read = $urandom;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    slot_req = '1;
    tick();
    n_cmp++;
    if ({slot_we, din_ok, dout, sdram_req, sdram_addr, busy, timeout} !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs: got we=%b ok=%b dout=%h req=%b addr=%h busy=%b to=%b want all 0",
               slot_we, din_ok, dout, sdram_req, sdram_addr, busy, timeout);
    end
    slot_req = '0;
    rst_n = 1'b1;
    model_last = N - 1;
    tick();
    n_cmp++;
    if (busy !== 1'b0 || sdram_req !== 1'b0) begin
      n_fail++;
      $display("FAIL idle_no_req: got busy=%b req=%b want 0 0", busy, sdram_req);
    end
  endtask

  task automatic test_single();
    do_reset();
    load_addrs();
    addr_tbl[2] = 22'h01234;
    slot_addr[44 +: 22] = 22'h01234;
    slot_req = 4'b0100;
    tick();
    n_cmp++;
    if (sdram_req !== 1'b1 || sdram_addr !== 22'h01234 || slot_we !== 4'b0100) begin
      n_fail++;
      $display("FAIL single_grant: got req=%b addr=%h we=%b want 1 01234 0100",
               sdram_req, sdram_addr, slot_we);
    end
    slot_req = '0;
    slot_addr[44 +: 22] = 22'h3ffff;
    serve(2, 3, 32'hDEADBEEF, 1'b0);
    n_cmp++;
    if (din_ok !== 1'b1 || dout !== 32'hDEADBEEF || slot_we !== 4'b0100 ||
        sdram_addr !== 22'h01234) begin
      n_fail++;
      $display("FAIL single_data: got ok=%b dout=%h we=%b addr=%h want 1 deadbeef 0100 01234",
               din_ok, dout, slot_we, sdram_addr);
    end
    tick();
    n_cmp++;
    if (din_ok !== 1'b0 || slot_we !== 4'b0000 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL single_done: got ok=%b we=%b busy=%b want 0 0000 0", din_ok, slot_we, busy);
    end
    model_last = 2;
    sdram_ack = 1'b1;
    data_rdy = 1'b1;
    tick();
    sdram_ack = 1'b0;
    data_rdy = 1'b0;
    tick();
    n_cmp++;
    if (busy !== 1'b0 || din_ok !== 1'b0 || sdram_req !== 1'b0) begin
      n_fail++;
      $display("FAIL stray_idle: got busy=%b ok=%b req=%b want 0 0 0", busy, din_ok, sdram_req);
    end
  endtask

  task automatic test_simultaneous();
    logic [31:0] d0, d3;
    do_reset();
    load_addrs();
    d0 = $urandom;
    d3 = $urandom;
    slot_req = 4'b1001;
    tick();
    n_cmp++;
    if (slot_we !== 4'b0001 || sdram_addr !== addr_tbl[0]) begin
      n_fail++;
      $display("FAIL simul_first: got we=%b addr=%h want 0001 %h", slot_we, sdram_addr, addr_tbl[0]);
    end
    serve(1, 1, d0, 1'b0);
    n_cmp++;
    if (din_ok !== 1'b1 || dout !== d0 || slot_we !== 4'b0001) begin
      n_fail++;
      $display("FAIL simul_data0: got ok=%b dout=%h we=%b want 1 %h 0001", din_ok, dout, slot_we, d0);
    end
    tick();
    n_cmp++;
    if (slot_we !== 4'b0000) begin
      n_fail++;
      $display("FAIL simul_gap: got we=%b want 0000", slot_we);
    end
    tick();
    n_cmp++;
    if (slot_we !== 4'b1000 || sdram_addr !== addr_tbl[3]) begin
      n_fail++;
      $display("FAIL simul_second: got we=%b addr=%h want 1000 %h", slot_we, sdram_addr, addr_tbl[3]);
    end
    slot_req = '0;
    serve(1, 2, d3, 1'b0);
    n_cmp++;
    if (din_ok !== 1'b1 || dout !== d3) begin
      n_fail++;
      $display("FAIL simul_data3: got ok=%b dout=%h want 1 %h", din_ok, dout, d3);
    end
    tick();
    model_last = 3;
  endtask

  task automatic test_all_continuous();
    int seq [6] = '{0, 1, 2, 3, 0, 1};
    logic [31:0] d;
    load_addrs();
    slot_req = 4'b1111;
    for (int t = 0; t < 6; t++) begin
      tick();
      n_cmp++;
      if (slot_we !== (N'(1) << seq[t]) || sdram_addr !== addr_tbl[seq[t]]) begin
        n_fail++;
        $display("FAIL rr_order[%0d]: got we=%b addr=%h want slot %0d", t, slot_we, sdram_addr, seq[t]);
      end
      d = $urandom;
      serve(2, 2, d, 1'b0);
      n_cmp++;
      if (din_ok !== 1'b1 || dout !== d) begin
        n_fail++;
        $display("FAIL rr_data[%0d]: got ok=%b dout=%h want 1 %h", t, din_ok, dout, d);
      end
      tick();
    end
    slot_req = '0;
    model_last = 1;
  endtask

  task automatic test_same_cycle();
    logic [N-1:0] mask;
    int w;
    mask = N'($urandom_range(1, 15));
    w = exp_winner(mask, model_last);
    slot_req = mask;
    tick();
    n_cmp++;
    if (slot_we !== (N'(1) << w)) begin
      n_fail++;
      $display("FAIL same_grant: got we=%b want slot %0d (mask %b)", slot_we, w, mask);
    end
    slot_req = '0;
    serve(1 + $urandom_range(0, 2), 0, 32'h00000055, 1'b0);
    n_cmp++;
    if (din_ok !== 1'b1 || dout !== 32'h00000055) begin
      n_fail++;
      $display("FAIL same_data: got ok=%b dout=%h want 1 00000055", din_ok, dout);
    end
    tick();
    n_cmp++;
    if (busy !== 1'b0 || din_ok !== 1'b0) begin
      n_fail++;
      $display("FAIL same_idle: got busy=%b ok=%b want 0 0", busy, din_ok);
    end
    model_last = w;
  endtask

  task automatic test_timeout();
    logic [N-1:0] mask;
    logic [31:0] d;
    int w, at;
    bit seen, dok;
    mask = N'($urandom_range(1, 15));
    w = exp_winner(mask, model_last);
    slot_req = mask;
    tick();
    slot_req = '0;
    seen = 1'b0;
    dok = 1'b0;
    at = 0;
    for (int c = 1; c <= 40 && !seen; c++) begin
      sdram_ack = (c == 2);
      tick();
      if (din_ok) dok = 1'b1;
      if (timeout) begin
        seen = 1'b1;
        at = c;
      end
    end
    sdram_ack = 1'b0;
    n_cmp++;
    if (!seen || at != 15) begin
      n_fail++;
      $display("FAIL timeout_cycle: got seen=%0d at=%0d want pulse 15 cycles after grant", seen, at);
    end
    n_cmp++;
    if (slot_we !== '0 || sdram_req !== 1'b0 || dok) begin
      n_fail++;
      $display("FAIL timeout_state: got we=%b req=%b din_ok_seen=%0d want 0 0 0", slot_we, sdram_req, dok);
    end
    tick();
    n_cmp++;
    if (timeout !== 1'b0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL timeout_pulse_len: got to=%b busy=%b want 0 0", timeout, busy);
    end
    model_last = w;
    mask = N'($urandom_range(1, 15));
    w = exp_winner(mask, model_last);
    slot_req = mask;
    tick();
    n_cmp++;
    if (slot_we !== (N'(1) << w)) begin
      n_fail++;
      $display("FAIL after_timeout_grant: got we=%b want slot %0d (mask %b)", slot_we, w, mask);
    end
    slot_req = '0;
    d = $urandom;
    serve(1, 1, d, 1'b0);
    n_cmp++;
    if (din_ok !== 1'b1 || dout !== d) begin
      n_fail++;
      $display("FAIL after_timeout_data: got ok=%b dout=%h want 1 %h", din_ok, dout, d);
    end
    tick();
    model_last = w;
  endtask

  task automatic test_reset_mid();
    logic [N-1:0] mask;
    logic [31:0] d;
    slot_req = N'($urandom_range(1, 15));
    tick();
    slot_req = '0;
    sdram_ack = 1'b1;
    tick();
    sdram_ack = 1'b0;
    tick();
    #2 rst_n = 1'b0;
    #1;
    n_cmp++;
    if ({slot_we, din_ok, dout, sdram_req, sdram_addr, busy, timeout} !== '0) begin
      n_fail++;
      $display("FAIL midreset_outputs: got we=%b ok=%b dout=%h req=%b addr=%h busy=%b to=%b want all 0",
               slot_we, din_ok, dout, sdram_req, sdram_addr, busy, timeout);
    end
    tick();
    rst_n = 1'b1;
    model_last = N - 1;
    data_rdy = 1'b1;
    data_read = $urandom;
    tick();
    data_rdy = 1'b0;
    tick();
    n_cmp++;
    if (din_ok !== 1'b0 || busy !== 1'b0 || dout !== '0 || timeout !== 1'b0) begin
      n_fail++;
      $display("FAIL midreset_stray: got ok=%b busy=%b dout=%h to=%b want 0 0 0 0",
               din_ok, busy, dout, timeout);
    end
    mask = N'($urandom_range(0, 15)) | N'(1);
    slot_req = mask;
    tick();
    n_cmp++;
    if (slot_we !== 4'b0001) begin
      n_fail++;
      $display("FAIL midreset_grant: got we=%b want 0001 (mask %b)", slot_we, mask);
    end
    slot_req = '0;
    d = $urandom;
    serve(2, 1, d, 1'b0);
    n_cmp++;
    if (din_ok !== 1'b1 || dout !== d) begin
      n_fail++;
      $display("FAIL midreset_data: got ok=%b dout=%h want 1 %h", din_ok, dout, d);
    end
    tick();
    model_last = 0;
  endtask

  task automatic test_random();
    logic [N-1:0] mask;
    logic [31:0] d;
    int w;
    for (int t = 0; t < 30; t++) begin
      load_addrs();
      mask = N'($urandom_range(1, 15));
      w = exp_winner(mask, model_last);
      slot_req = mask;
      tick();
      n_cmp++;
      if (slot_we !== (N'(1) << w) || sdram_addr !== addr_tbl[w] || sdram_req !== 1'b1) begin
        n_fail++;
        $display("FAIL rand_grant[%0d]: got we=%b addr=%h req=%b want slot %0d addr %h (mask %b)",
                 t, slot_we, sdram_addr, sdram_req, w, addr_tbl[w], mask);
      end
      if ($urandom_range(0, 1) == 1) slot_req = '0;
      slot_addr = {$urandom, $urandom, $urandom};
      d = $urandom;
      serve($urandom_range(1, 4), $urandom_range(0, 5), d, 1'($urandom_range(0, 1)));
      n_cmp++;
      if (din_ok !== 1'b1 || dout !== d || slot_we !== (N'(1) << w) || sdram_addr !== addr_tbl[w]) begin
        n_fail++;
        $display("FAIL rand_data[%0d]: got ok=%b dout=%h we=%b addr=%h want 1 %h slot %0d addr %h",
                 t, din_ok, dout, slot_we, sdram_addr, d, w, addr_tbl[w]);
      end
      tick();
      n_cmp++;
      if (slot_we !== '0 || din_ok !== 1'b0) begin
        n_fail++;
        $display("FAIL rand_done[%0d]: got we=%b ok=%b want 0 0", t, slot_we, din_ok);
      end
      model_last = w;
    end
    slot_req = '0;
  endtask

  initial begin
    test_reset();
    test_single();
    test_simultaneous();
    test_all_continuous();
    test_same_cycle();
    test_timeout();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
